// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the unified memory port arbiter: the arbiter
// state encoding, default bus widths and timeout, requester ids and a
// small helper that maps a requester id to its grant state.
// No ports (package).

package mem_port_arbiter_pkg;

    localparam int AW_DEF      = 32;
    localparam int DW_DEF      = 32;
    localparam int TIMEOUT_DEF = 255;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_DM = 2'd1,
        GRANT_IF = 2'd2,
        ERR      = 2'd3
    } arb_state_t;

    // Grant state that serves the given requester.
    function automatic arb_state_t grant_state(input logic id);
        return (id == REQ_DM) ? GRANT_DM : GRANT_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the fetch-stage, memory-stage and memory-array handshakes of the
// arbiter into one interface.
//   fetch : if_req, if_addr -> if_rdata, if_done
//   data  : dm_req, dm_we, dm_addr, dm_wdata -> dm_rdata, dm_done
//   memory: mem_req, mem_we, mem_addr, mem_wdata <- mem_rdata, mem_ready
//   status: stall, err
// Modports: master = arbiter view, slave = pipeline/memory view.

interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_done;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    logic          stall;
    logic          err;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
               mem_rdata, mem_ready,
        output if_rdata, if_done, dm_rdata, dm_done,
               mem_req, mem_we, mem_addr, mem_wdata, stall, err
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
               mem_rdata, mem_ready,
        input  if_rdata, if_done, dm_rdata, dm_done,
               mem_req, mem_we, mem_addr, mem_wdata, stall, err
    );

endinterface

// File: rtl/mem_port_arbiter_arb_watchdog.sv
// arb_watchdog
// Wait-cycle counter for a granted memory access.
//   clk     in  clock
//   rst     in  synchronous active-low reset
//   clr     in  force the count back to zero
//   en      in  count one more wait cycle
//   expired out count has reached TIMEOUT

module arb_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
)(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // Wide enough to hold TIMEOUT itself, with a floor of one bit.
    localparam int CW = $clog2(TIMEOUT + 2);

    logic [CW-1:0] count_q;

    // Counter saturates at TIMEOUT; clearing has priority over counting.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            count_q <= '0;
        end else if (en && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = (count_q == CW'(TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one variable-latency memory port between instruction fetch and
// the memory stage. Data accesses win ties because the memory-stage
// instruction is older. Stalls the pipeline while any request is pending
// and locks into a sticky error if a granted access never completes.
//   clk  in  clock
//   rst  in  synchronous active-low reset
//   bus  master modport of mem_port_arbiter_if (fetch, data, memory,
//        stall and err signals)

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
)(
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);

    arb_state_t    state_q;
    logic          req_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          if_done_q;
    logic          dm_done_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] dm_rdata_q;
    logic          err_q;

    logic          granted;
    logic          expired;

    assign granted = (state_q == GRANT_DM) || (state_q == GRANT_IF);

    // The wait counter restarts whenever no access is in flight, so each
    // grant begins counting from zero.
    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (!granted),
        .en      (granted && !bus.mem_ready),
        .expired (expired)
    );

    // Arbiter FSM. Memory-side outputs come only from the registers latched
    // at grant time. A requester whose done pulse is high this cycle is
    // still holding its request, so it is masked to avoid a second grant.
    // On completion mem_ready is checked before the timeout so a late
    // answer on the final allowed cycle still succeeds.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.dm_req && !dm_done_q) begin
                        state_q <= grant_state(REQ_DM);
                        req_q   <= 1'b1;
                        we_q    <= bus.dm_we;
                        addr_q  <= bus.dm_addr;
                        wdata_q <= bus.dm_wdata;
                    end else if (bus.if_req && !if_done_q) begin
                        state_q <= grant_state(REQ_IF);
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        addr_q  <= bus.if_addr;
                    end
                end
                GRANT_DM: begin
                    if (bus.mem_ready) begin
                        if (!we_q) begin
                            dm_rdata_q <= bus.mem_rdata;
                        end
                        dm_done_q <= 1'b1;
                        req_q     <= 1'b0;
                        we_q      <= 1'b0;
                        state_q   <= IDLE;
                    end else if (expired) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ERR;
                    end
                end
                GRANT_IF: begin
                    if (bus.mem_ready) begin
                        if_rdata_q <= bus.mem_rdata;
                        if_done_q  <= 1'b1;
                        req_q      <= 1'b0;
                        state_q    <= IDLE;
                    end else if (expired) begin
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ERR;
                    end
                end
                ERR: begin
                    req_q <= 1'b0;
                    we_q  <= 1'b0;
                    err_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_done   = dm_done_q;
    assign bus.err       = err_q;

    // Stall follows the live requests so the pipeline releases in the
    // same cycle the done pulse arrives.
    assign bus.stall = (bus.if_req & ~if_done_q)
                     | (bus.dm_req & ~dm_done_q)
                     | (state_q == ERR);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Drives fetch/data transactions with random addresses, data and memory
// latencies and compares the arbiter against a transaction-level model of
// the memory contents and the documented request-to-done timing.

module tb_mem_port_arbiter;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int check_count = 0;
    int pass_count  = 0;

    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_dm_rdata;

    // Single comparison point: counts and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory contents: written values, otherwise an address-derived pattern.
    function automatic logic [31:0] modelRead(input logic [31:0] a);
        if (mem_model.exists(a)) begin
            return mem_model[a];
        end
        return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
    endfunction

    task automatic driveIdle();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.dm_req    = 1'b0;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = '0;
        bus.dm_wdata  = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
    endtask

    // Pulls reset across one edge and checks every output is cleared.
    task automatic resetDut();
        driveIdle();
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_mem_req",   bus.mem_req,   0);
        checkOutput("rst_mem_we",    bus.mem_we,    0);
        checkOutput("rst_if_done",   bus.if_done,   0);
        checkOutput("rst_dm_done",   bus.dm_done,   0);
        checkOutput("rst_err",       bus.err,       0);
        checkOutput("rst_stall",     bus.stall,     0);
        checkOutput("rst_mem_addr",  bus.mem_addr,  0);
        checkOutput("rst_mem_wdata", bus.mem_wdata, 0);
        checkOutput("rst_if_rdata",  bus.if_rdata,  0);
        checkOutput("rst_dm_rdata",  bus.dm_rdata,  0);
        exp_if_rdata = '0;
        exp_dm_rdata = '0;
        rst = 1'b1;
    endtask

    // One transaction: optional data access and/or fetch presented together
    // at cycle 0, memory answering after k_dm / k_if wait cycles. Requests
    // stay high through their done cycle and drop the cycle after.
    // Called and returns at 1 time unit after a rising edge.
    task automatic applyStimulus(input bit do_if, input bit do_dm, input bit we,
                                 input logic [31:0] ia, input logic [31:0] da,
                                 input logic [31:0] wd, input int k_dm, input int k_if);
        int dm_end, if_start, if_end, last;
        logic [31:0] dm_val, if_val;
        dm_end   = do_dm ? 1 + k_dm : -5;
        if_start = do_dm ? dm_end + 2 : 1;
        if_end   = do_if ? if_start + k_if : -5;
        last     = 0;
        if (do_dm) last = dm_end + 1;
        if (do_if && if_end + 1 > last) last = if_end + 1;
        dm_val = '0;
        if_val = '0;
        for (int c = 0; c <= last + 1; c++) begin
            bit in_dm, in_if, exp_req, exp_if_done, exp_dm_done, if_req_now, dm_req_now;
            in_dm       = do_dm && c >= 1 && c <= dm_end;
            in_if       = do_if && c >= if_start && c <= if_end;
            exp_req     = in_dm || in_if;
            exp_dm_done = do_dm && c == dm_end + 1;
            exp_if_done = do_if && c == if_end + 1;
            dm_req_now  = do_dm && c <= dm_end + 1;
            if_req_now  = do_if && c <= if_end + 1;
            bus.dm_req  = dm_req_now;
            bus.if_req  = if_req_now;
            if (c == 0) begin
                bus.dm_we    = we;
                bus.dm_addr  = da;
                bus.dm_wdata = wd;
                bus.if_addr  = ia;
            end else begin
                bus.dm_we    = 1'($urandom_range(0, 1));
                bus.dm_addr  = $urandom;
                bus.dm_wdata = $urandom;
                if (!do_if || c >= if_start) bus.if_addr = $urandom;
            end
            bus.mem_rdata = $urandom;
            if (in_dm) begin
                bus.mem_ready = (c == dm_end);
                if (c == dm_end) begin
                    if (we) begin
                        mem_model[da] = wd;
                    end else begin
                        dm_val = modelRead(da);
                        bus.mem_rdata = dm_val;
                    end
                end
            end else if (in_if) begin
                bus.mem_ready = (c == if_end);
                if (c == if_end) begin
                    if_val = modelRead(ia);
                    bus.mem_rdata = if_val;
                end
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
            if (exp_dm_done && !we) exp_dm_rdata = dm_val;
            if (exp_if_done) exp_if_rdata = if_val;
            #1;
            checkOutput("mem_req", bus.mem_req, exp_req);
            if (exp_req) begin
                checkOutput("mem_addr", bus.mem_addr, in_dm ? da : ia);
                checkOutput("mem_we", bus.mem_we, in_dm && we);
                if (in_dm && we) checkOutput("mem_wdata", bus.mem_wdata, wd);
            end
            checkOutput("if_done",  bus.if_done,  exp_if_done);
            checkOutput("dm_done",  bus.dm_done,  exp_dm_done);
            checkOutput("if_rdata", bus.if_rdata, exp_if_rdata);
            checkOutput("dm_rdata", bus.dm_rdata, exp_dm_rdata);
            checkOutput("err",      bus.err,      0);
            checkOutput("stall",    bus.stall,
                        (if_req_now && !exp_if_done) || (dm_req_now && !exp_dm_done));
            @(posedge clk);
            #1;
        end
        driveIdle();
    endtask

    // Fetch that is never answered: granted for TMO+1 cycles, then a
    // permanent error that ignores mem_ready and survives dropped requests.
    task automatic runTimeout();
        for (int c = 0; c <= TMO + 7; c++) begin
            bit exp_err, exp_req, req_now;
            exp_req = c >= 1 && c <= TMO + 1;
            exp_err = c >= TMO + 2;
            req_now = c <= TMO + 3;
            bus.if_req    = req_now;
            bus.if_addr   = 32'h0000_0100;
            bus.mem_ready = exp_err ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.mem_rdata = $urandom;
            #1;
            checkOutput("tmo_mem_req", bus.mem_req, exp_req);
            checkOutput("tmo_err",     bus.err,     exp_err);
            checkOutput("tmo_stall",   bus.stall,   req_now || exp_err);
            checkOutput("tmo_if_done", bus.if_done, 0);
            @(posedge clk);
            #1;
        end
        resetDut();
    endtask

    initial begin
        logic [31:0] ra, rb, rw;
        int kind;
        driveIdle();
        rst = 1'b0;
        @(posedge clk);
        #1;
        resetDut();

        mem_model[32'h10] = 32'hDEADBEEF;
        applyStimulus(1, 0, 0, 32'h10, 32'h0, 32'h0, 0, 0);

        mem_model[32'h40] = 32'h0000_1234;
        applyStimulus(1, 1, 0, 32'h20, 32'h40, 32'h0, 2, 2);

        applyStimulus(0, 1, 1, 32'h0, 32'h80, 32'hA5A5A5A5, 1, 0);
        applyStimulus(1, 1, 0, 32'h80, 32'h80, 32'h0, 0, TMO);

        runTimeout();

        // Reset while a fetch is waiting on memory.
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h44;
        bus.mem_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("mid_mem_req", bus.mem_req, 1);
        resetDut();
        applyStimulus(1, 0, 0, 32'h44, 32'h0, 32'h0, 0, 1);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            ra   = 32'($urandom_range(0, 15)) << 2;
            rb   = 32'($urandom_range(0, 15)) << 2;
            rw   = $urandom;
            applyStimulus(kind != 1, kind != 0, 1'($urandom_range(0, 1)), ra, rb, rw,
                          $urandom_range(0, TMO), $urandom_range(0, TMO));
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
